// File: rtl/bip_report_pkg.sv
// Shared definitions for the BIP end-of-run UART report transmitter.
// Optional BIP_REPORT_CHECKSUM_EN appends an XOR checksum byte to the report.
package bip_report_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0]  REPORT_HEADER = 8'hA5;
  localparam int unsigned REPORT_BYTES  = 7;

`ifdef BIP_REPORT_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = REPORT_BYTES + 1;
`else
  localparam int unsigned FRAME_BYTES = REPORT_BYTES;
`endif

  localparam int unsigned IDX_W = 4;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serialiser: one start bit, eight data bits LSB first, one stop bit.
// A start presented on the edge that ends a stop bit chains the next byte with no gap.
module uart_tx_byte #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done
);

  localparam int unsigned     DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             active_q, active_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;     // 0 start, 1..8 data, 9 stop
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end   = active_q && (div_q == DIV_LAST);
  assign byte_done = bit_end && (bit_q == 4'd9);
  assign tx        = tx_q;

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    if (active_q) begin
      div_d = bit_end ? '0 : div_q + 1'b1;
    end
    if (bit_end) begin
      if (bit_q == 4'd9) begin
        active_d = 1'b0;
        tx_d     = 1'b1;
      end else if (bit_q == 4'd8) begin
        bit_d = 4'd9;
        tx_d  = 1'b1;
      end else begin
        bit_d   = bit_q + 4'd1;
        tx_d    = shift_q[0];
        shift_d = {1'b0, shift_q[7:1]};
      end
    end
    if (start && (!active_q || byte_done)) begin
      active_d = 1'b1;
      div_d    = '0;
      bit_d    = 4'd0;
      shift_d  = data;
      tx_d     = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= 4'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/bip_report_tx.sv
// On BIP halt, snapshots pc/acc/cycle count and sends a one-shot UART report.
// Define BIP_REPORT_CHECKSUM_EN to append an XOR checksum byte after the 7 report bytes.
module bip_report_tx
  import bip_report_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16,
  parameter int unsigned PC_W    = 11,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] acc,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES);

  state_e           state_q, state_d;
  logic [15:0]      cyc_q, cyc_d;
  logic [15:0]      pc_q, pc_d;
  logic [15:0]      acc_q, acc_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;   // bytes handed to the serialiser so far
  logic             start;
  logic             byte_done;
  logic [7:0]       byte_data;

`ifdef BIP_REPORT_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = REPORT_HEADER ^ pc_q[15:8] ^ pc_q[7:0] ^ acc_q[15:8] ^ acc_q[7:0]
                  ^ cnt_q[15:8] ^ cnt_q[7:0];
`endif

  always_comb begin
    case (idx_q)
      4'd0:    byte_data = REPORT_HEADER;
      4'd1:    byte_data = pc_q[15:8];
      4'd2:    byte_data = pc_q[7:0];
      4'd3:    byte_data = acc_q[15:8];
      4'd4:    byte_data = acc_q[7:0];
      4'd5:    byte_data = cnt_q[15:8];
      4'd6:    byte_data = cnt_q[7:0];
`ifdef BIP_REPORT_CHECKSUM_EN
      4'd7:    byte_data = checksum;
`endif
      default: byte_data = 8'hFF;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (halt) begin
          pc_d    = 16'(pc);
          acc_d   = 16'(acc);
          cnt_d   = cyc_q;
          idx_d   = '0;
          state_d = ST_SEND;
        end else if (cyc_q != 16'hFFFF) begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      ST_SEND: begin
        // The first byte launches one edge after the snapshot; the rest chain on byte_done.
        start = (idx_q != LAST_IDX) && ((idx_q == '0) || byte_done);
        if (start) begin
          idx_d = idx_q + 1'b1;
        end else if (byte_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the snapshot registers are cleared on reset too, so the bench never sees X on a report byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cyc_q   <= 16'h0000;
      pc_q    <= 16'h0000;
      acc_q   <= 16'h0000;
      cnt_q   <= 16'h0000;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign busy = (state_q == ST_SEND);
  assign done = (state_q == ST_DONE);

  uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_uart (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data      (byte_data),
    .tx        (tx),
    .byte_done (byte_done)
  );

endmodule

// File: doc/bip_report_tx.md
BIP_REPORT_TX -- requirements
Module: bip_report_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clock cycles per UART bit, legal range 2..65535.
REQ-002 SHALL have parameter PC_W, default 11: width of the BIP program counter.
REQ-003 SHALL have parameter DATA_W, default 16: width of the BIP accumulator.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port halt, input, 1 bit: level; BIP has executed HLT.
REQ-007 SHALL have port pc, input, PC_W bits: BIP program counter.
REQ-008 SHALL have port acc, input, DATA_W bits: BIP accumulator.
REQ-009 SHALL have port tx, output, 1 bit: UART 8N1 serial line, idle high.
REQ-010 SHALL have port busy, output, 1 bit: a report is in transmission.
REQ-011 SHALL have port done, output, 1 bit: sticky flag; report completed.

Function
REQ-012 SHALL keep a 16-bit cycle counter that increments each cycle with reset=0 and state IDLE and halt=0, and saturates at 0xFFFF.
REQ-013 SHALL implement FSM states IDLE, SEND, DONE.
REQ-014 SHALL, in IDLE, when halt=1 is sampled at edge k: snapshot pc, acc and the cycle count at edge k, and go to SEND.
REQ-015 SHALL drive the first start bit (tx=0) from edge k+1.
REQ-016 SHALL send the report bytes in this order: 0xA5; pc zero-extended to 16 bits, high byte then low byte; acc high byte, acc low byte; cycle count high byte, cycle count low byte (7 bytes).
REQ-017 SHALL frame each byte as: start bit 0, 8 data bits LSB first, stop bit 1; each bit is exactly CLK_DIV cycles.
REQ-018 SHALL send bytes back-to-back with no idle gap; frame length = bytes x 10 x CLK_DIV cycles.
REQ-019 SHALL, on the edge that ends the final stop bit, go to DONE, set done=1 and set busy=0.
REQ-020 SHALL make DONE terminal until reset: further halt activity is ignored and tx stays 1.
REQ-021 SHALL set busy=1 exactly while in SEND.
REQ-022 SHALL let a frame complete unchanged if halt deasserts or pc/acc change mid-frame; only the snapshot is transmitted.
REQ-023 SHALL, if halt=1 on the first cycle after reset deasserts, report a cycle count of 0.

Reset
REQ-024 SHALL, while reset=1, force tx=1, busy=0, done=0, state=IDLE, cycle counter=0, bit/byte counters=0.
REQ-025 SHALL, on reset asserted mid-frame, bring tx to 1 at the next edge; the partial frame is abandoned and not resumed.

Configuration
REQ-026 SHALL use macro BIP_REPORT_CHECKSUM_EN: when defined, append an 8th byte equal to the XOR of the 7 report bytes; when undefined, send exactly 7 bytes and compile no checksum logic.

Structure
REQ-027 SHALL define in shared package bip_report_pkg: the FSM state encoding, the header constant 0xA5, and the report byte count.
REQ-028 SHALL use one sub-module, uart_tx_byte (CLK_DIV parameter; start/data in; tx and byte_done out), instantiated once.

Verification
Common settings: CLK_DIV=4; checksum byte expected only when BIP_REPORT_CHECKSUM_EN is defined.
REQ-029 SHALL test: reset release, halt=0 for 100 cycles, then halt=1 with pc=0x005, acc=0x1234 -> bytes A5 00 05 12 34 00 64 (+E2 checksum); done=1 after 280 cycles (320 with checksum).
REQ-030 SHALL test: halt held low for 70000 cycles, then raised -> cycle bytes FF FF (saturation).
REQ-031 SHALL test: change acc to 0xFFFF and drop halt during byte 2 -> transmitted acc bytes remain 12 34.
REQ-032 SHALL test: assert reset for 1 cycle during byte 4 -> tx=1, busy=0, done=0 on the next edge; re-raising halt restarts the frame with header A5.
REQ-033 SHALL test: after done=1, toggle halt repeatedly -> tx stays 1 and no new start bit appears.
REQ-034 SHALL test: halt=1 already on the first cycle after reset -> cycle bytes 00 00; start bit appears one cycle after halt is sampled.
